instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
// - Packs decoded fields (kind, rd, rs1, rs2, funct3, 64-bit signed immediate) into a 32-bit RV64 instruction word.
// - It is the inverse of the immediate-extend path and covers load (I-type), store (S-type) and branch (B-type).
// - Used by the instruction-memory preloader and by self-check benches.
// - Buffered through a pipeline register and an output FIFO with valid/ready on both sides.
// PARAMETERS
// - DEPTH  4   output FIFO entries (power of 2, >=2)
// - CNT_W  16  width of the accepted/rejected counters
// PORTS
// - clk        in   1      single clock, rising edge
// - reset      in   1      asynchronous, active-high
// - in_valid   in   1      request valid
// - in_ready   out  1      request accepted when in_valid&&in_ready
// - in_kind    in   2      enc_kind_t: 0=LD, 1=SD, 2=BR, 3=reserved
// - in_rd      in   5      destination (LD only)
// - in_rs1     in   5      source 1
// - in_rs2     in   5      source 2 (SD/BR)
// - in_funct3  in   3      copied verbatim into bits[14:12]
// - in_imm     in   64     signed immediate (byte offset)
// - out_valid  out  1      FIFO head valid
// - out_ready  in   1      consumer pop
// - out_instr  out  32     encoded instruction (FIFO head)
// - err_valid  out  1      one-cycle pulse: request rejected
// - err_code   out  2      0=none, 1=imm out of range, 2=branch imm odd, 3=bad kind
// - acc_cnt    out  CNT_W  encoded words written to the FIFO, wraps
// - rej_cnt    out  CNT_W  rejected requests, wraps
// BEHAVIOUR
// - Reset (async, any cycle): pipe/FIFO emptied, counters 0, err_valid=0, err_code=0, out_instr=0. In-flight data is discarded.
// - Encoding:
//   - LD: {imm[11:0],rs1,f3,rd,7'b0000011}
//   - SD: {imm[11:5],rs2,rs1,f3,imm[4:0],7'b0100011}
//   - BR: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],7'b1100011}
// - Range checks:
//   - LD/SD require imm in [-2048,2047], i.e. bits[63:11] all equal.
//   - BR requires imm in [-4096,4094], i.e. bits[63:12] all equal, and imm[0]=0.
//   - Priority when several fail: bad kind > odd > range.
// - Stage S1 (one register) holds the encoded word and error info.
//   - in_ready = !s1_valid || s1_leaves, where s1_leaves = s1_err || fifo_push_ok.
//   - fifo_push_ok = count<DEPTH || (out_valid&&out_ready).
// - Rejected requests are still consumed (handshake completes) and never reach the FIFO.
//   - err_valid pulses for the cycle S1 holds them, err_code is valid alongside it, and rej_cnt increments.
//   - err_code returns to 0 otherwise.
// - Accepted good request at edge k:
//   - S1 is loaded at k and pushed at k+1 if there is space.
//   - out_valid is high from edge k+1 onward, giving 2-edge latency into an empty FIFO.
//   - acc_cnt increments on the push.
// - FIFO is show-ahead: out_instr is the head and is stable while out_valid && !out_ready.
// - Full FIFO with simultaneous pop: push and pop in the same cycle, and count is unchanged.
// - Empty FIFO: out_valid=0 and out_instr holds its last value; a pop with out_valid=0 is ignored.
// - Pointers wrap modulo DEPTH; count is tracked separately in $clog2(DEPTH)+1 bits.
// - Counters wrap at 2^CNT_W.
// - Full throughput is 1 request/cycle while out_ready=1.
// CONFIGURATION
// - Macro INSTR_ENC_ROUNDTRIP_CHECK_EN.
// - Defined:
//   - S1 re-extends its own encoded word with the extend rules and compares the result to the original imm.
//   - A mismatch on a non-error entry raises sticky output rt_mismatch (1 bit, cleared only by reset) and fires an immediate assertion in simulation.
// - Undefined: rt_mismatch port and checker are absent, and the datapath is identical.
// STRUCTURE
// - Package instr_enc_pkg holds:
//   - enc_kind_t enum
//   - err_code_t enum
//   - OPC_LOAD/OPC_STORE/OPC_BRANCH 7-bit constants
//   - function fits_signed(imm,bits)
// - Sub-module instr_enc_fifo: parameterised DEPTH x 32, show-ahead, push/pop/count, async reset.
// - The top level holds the combinational packer, range check, S1 and the counters.
// TESTING
// - LD rd=5 rs1=2 f3=3 imm=-8 -> out_instr=32'hFF813283, out_valid 2 edges after accept, acc_cnt=1.
// - SD rs1=2 rs2=7 f3=3 imm=2047 -> 32'h7E713FA3; BR rs1=1 rs2=2 f3=0 imm=-4096 -> 32'h80208063.
// - BR imm=6 plus odd imm=3 -> first encoded, second err_valid pulse with err_code=2, rej_cnt=1, no FIFO entry.
// - LD imm=2048 -> err_code=1; kind=3 -> err_code=3; in_ready stays 1 and throughput is uninterrupted.
// - out_ready=0 with 6 back-to-back requests (DEPTH=4):
//   - in_ready drops once the FIFO is full and S1 is occupied.
//   - After out_ready=1, all 5 buffered words drain in order; simultaneous push/pop at full holds count=4.
// - Assert reset mid-burst -> outputs zero immediately (async) and out_valid=0; after release the first new request is encoded correctly.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// Shared types and constants for the RV64 load/store/branch instruction
// encoder: request kinds, rejection codes, major opcodes and the signed
// immediate range helper.
package instr_enc_pkg;

    typedef enum logic [1:0] {
        KIND_LD  = 2'd0,
        KIND_SD  = 2'd1,
        KIND_BR  = 2'd2,
        KIND_RSV = 2'd3
    } enc_kind_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_RANGE = 2'd1,
        ERR_ODD   = 2'd2,
        ERR_KIND  = 2'd3
    } err_code_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // True when imm is representable as a 'bits'-wide two's complement
    // value, i.e. every bit from bits-1 upward equals the sign bit.
    function automatic logic fits_signed(input logic [63:0] imm, input int bits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (i >= bits - 1 && imm[i] != imm[63]) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// Show-ahead FIFO, DEPTH x W, for encoded instruction words.
// Ports: clk, reset (async, active-high), push/din (write), pop (consumer
// ready), dout (head, or last popped word while empty), valid (non-empty),
// count (occupancy, $clog2(DEPTH)+1 bits).
// A push while full is accepted only when a pop happens in the same cycle.
module instr_enc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic [W-1:0]  last_q;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && ((cnt < FULL) || do_pop);

    // NOTE: storage is deliberately left out of reset; cnt guards every read,
    // so stale contents are never presented as valid data.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            last_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign valid = (cnt != '0);
    // While empty the output keeps showing the most recently popped word.
    assign dout  = valid ? mem[rd_ptr] : last_q;
    assign count = cnt;

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded fields into a 32-bit RV64 load (I), store (S) or branch (B)
// instruction word, buffered through one register stage (S1) and an output
// show-ahead FIFO with valid/ready handshakes on both sides.
// Ports: clk, reset (async, active-high); request in_valid/in_ready with
// in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_imm; result out_valid/
// out_ready/out_instr; err_valid/err_code pulse for rejected requests;
// acc_cnt/rej_cnt wrapping counters.
// Optional build macro INSTR_ENC_ROUNDTRIP_CHECK_EN adds the rt_mismatch
// output and a checker that re-extends each encoded word and compares it
// with the original immediate.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [63:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic [CNT_W-1:0]  acc_cnt,
    output logic [CNT_W-1:0]  rej_cnt
`ifdef INSTR_ENC_ROUNDTRIP_CHECK_EN
   ,output logic              rt_mismatch
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    enc_kind_t     kind;
    logic [31:0]   enc_word;
    err_code_t     enc_code;
    logic          s1_valid;
    logic [31:0]   s1_word;
    err_code_t     s1_code;
    logic          s1_err;
    logic [CW-1:0] fifo_count;
    logic          fifo_push_ok;
    logic          s1_leaves;
    logic          accept;
    logic          push;

    assign kind = enc_kind_t'(in_kind);

    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        enc_word = '0;
        enc_code = ERR_NONE;
        case (kind)
            KIND_LD: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD};
            KIND_SD: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                                 in_imm[4:0], OPC_STORE};
            KIND_BR: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                 in_imm[4:1], in_imm[11], OPC_BRANCH};
            default: enc_word = '0;
        endcase
        // Checks in priority order: bad kind, then odd branch target, then range.
        if (kind == KIND_RSV)
            enc_code = ERR_KIND;
        else if (kind == KIND_BR && in_imm[0])
            enc_code = ERR_ODD;
        else if (kind == KIND_BR ? !fits_signed(in_imm, 13) : !fits_signed(in_imm, 12))
            enc_code = ERR_RANGE;
    end

    // A rejected entry always leaves S1 after one cycle; a good one leaves
    // when the FIFO has room, counting a same-cycle pop as room.
    assign s1_err       = (s1_code != ERR_NONE);
    assign fifo_push_ok = (fifo_count < FULL) || (out_valid && out_ready);
    assign s1_leaves    = s1_err || fifo_push_ok;
    assign in_ready     = !s1_valid || s1_leaves;
    assign accept       = in_valid && in_ready;
    assign push         = s1_valid && !s1_err && fifo_push_ok;

    assign err_valid = s1_valid && s1_err;
    assign err_code  = err_valid ? s1_code : ERR_NONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_word  <= '0;
            s1_code  <= ERR_NONE;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_word  <= enc_word;
            s1_code  <= enc_code;
        end else if (s1_valid && s1_leaves) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_cnt <= '0;
            rej_cnt <= '0;
        end else begin
            if (push)      acc_cnt <= acc_cnt + 1'b1;
            if (err_valid) rej_cnt <= rej_cnt + 1'b1;
        end
    end

    instr_enc_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (s1_word),
        .pop   (out_ready),
        .dout  (out_instr),
        .valid (out_valid),
        .count (fifo_count)
    );

`ifdef INSTR_ENC_ROUNDTRIP_CHECK_EN
    enc_kind_t   s1_kind;
    logic [63:0] s1_imm;
    logic [63:0] rt_imm;
    logic        rt_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_kind <= KIND_LD;
            s1_imm  <= '0;
        end else if (accept) begin
            s1_kind <= kind;
            s1_imm  <= in_imm;
        end
    end

    // Sign-extend the immediate back out of the word exactly as a decoder would.
    always_comb begin
        rt_imm = '0;
        case (s1_kind)
            KIND_LD: rt_imm = {{52{s1_word[31]}}, s1_word[31:20]};
            KIND_SD: rt_imm = {{52{s1_word[31]}}, s1_word[31:25], s1_word[11:7]};
            KIND_BR: rt_imm = {{51{s1_word[31]}}, s1_word[31], s1_word[7],
                               s1_word[30:25], s1_word[11:8], 1'b0};
            default: rt_imm = s1_imm;
        endcase
    end

    assign rt_ok = (rt_imm == s1_imm);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rt_mismatch <= 1'b0;
        else if (s1_valid && !s1_err && !rt_ok)
            rt_mismatch <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset && s1_valid && !s1_err)
            assert (rt_ok) else $error("instr_encoder round-trip: word %h imm %h", s1_word, s1_imm);
    end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: reset state, first-word latency, a
// streamed table of good and rejected requests, backpressure at full FIFO,
// and asynchronous reset in the middle of a burst.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_kind = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [63:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic        err_valid;
    logic [1:0]  err_code;
    logic [15:0] acc_cnt;
    logic [15:0] rej_cnt;
`ifdef INSTR_ENC_ROUNDTRIP_CHECK_EN
    logic        rt_mismatch;
`endif

    instr_encoder #(.DEPTH(4), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .err_valid (err_valid),
        .err_code  (err_code),
        .acc_cnt   (acc_cnt),
        .rej_cnt   (rej_cnt)
`ifdef INSTR_ENC_ROUNDTRIP_CHECK_EN
       ,.rt_mismatch (rt_mismatch)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [63:0] imm;
        logic [1:0]  err;
        logic [31:0] instr;
    } vec_t;

    localparam int N = 15;
    vec_t tbl [N];

    int n_vec  = 0;
    int n_fail = 0;
    int exp_acc = 0;
    int exp_rej = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [1:0] kind, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [2:0] f3, input logic [63:0] imm,
                                 input logic [1:0] err, input logic [31:0] instr);
        vec_t v;
        v.kind = kind; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.f3 = f3; v.imm = imm; v.err = err; v.instr = instr;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_valid  = 1'b1;
        in_kind   = v.kind;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_funct3 = v.f3;
        in_imm    = v.imm;
    endtask

    // Load word with rd=j, rs1=1, funct3=2, imm=j, built arithmetically.
    function automatic logic [31:0] ld_word(input int j);
        return (32'(j) << 20) | 32'h0000_8000 | 32'h0000_2000 | (32'(j) << 7) | 32'h3;
    endfunction

    function automatic vec_t ld_vec(input int j);
        return mkv(2'd0, 5'(j), 5'd1, 5'd0, 3'd2, 64'(j), 2'd0, ld_word(j));
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // kind rd rs1 rs2 f3 imm err instr
        tbl[0]  = mkv(2'd1, 5'd0, 5'd2,  5'd7,  3'd3, 64'sd2047,  2'd0, 32'h7E713FA3);
        tbl[1]  = mkv(2'd2, 5'd0, 5'd1,  5'd2,  3'd0, -64'sd4096, 2'd0, 32'h80208063);
        tbl[2]  = mkv(2'd2, 5'd0, 5'd1,  5'd2,  3'd1, 64'sd6,     2'd0, 32'h00209363);
        tbl[3]  = mkv(2'd2, 5'd0, 5'd1,  5'd2,  3'd1, 64'sd3,     2'd2, 32'h0);
        tbl[4]  = mkv(2'd0, 5'd5, 5'd2,  5'd0,  3'd3, 64'sd2048,  2'd1, 32'h0);
        tbl[5]  = mkv(2'd3, 5'd0, 5'd0,  5'd0,  3'd0, 64'sd0,     2'd3, 32'h0);
        tbl[6]  = mkv(2'd0, 5'd0, 5'd0,  5'd0,  3'd0, 64'sd2047,  2'd0, 32'h7FF00003);
        tbl[7]  = mkv(2'd1, 5'd0, 5'd31, 5'd31, 3'd7, -64'sd2048, 2'd0, 32'h81FFF023);
        tbl[8]  = mkv(2'd2, 5'd0, 5'd0,  5'd0,  3'd0, 64'sd4094,  2'd0, 32'h7E000FE3);
        tbl[9]  = mkv(2'd0, 5'd5, 5'd2,  5'd0,  3'd3, -64'sd2049, 2'd1, 32'h0);
        tbl[10] = mkv(2'd2, 5'd0, 5'd1,  5'd2,  3'd0, -64'sd4097, 2'd2, 32'h0);
        tbl[11] = mkv(2'd2, 5'd0, 5'd1,  5'd2,  3'd0, 64'sd4096,  2'd1, 32'h0);
        tbl[12] = mkv(2'd3, 5'd0, 5'd1,  5'd2,  3'd0, 64'sd3,     2'd3, 32'h0);
        tbl[13] = mkv(2'd0, 5'd5, 5'd2,  5'd0,  3'd3, -64'sd2048, 2'd0, 32'h80013283);
        tbl[14] = mkv(2'd0, 5'd1, 5'd1,  5'd0,  3'd0, 64'h0000_0001_0000_0000, 2'd1, 32'h0);

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_instr", 64'(out_instr), 64'd0);
        check("rst err_valid", 64'(err_valid), 64'd0);
        check("rst err_code",  64'(err_code),  64'd0);
        check("rst acc_cnt",   64'(acc_cnt),   64'd0);
        check("rst rej_cnt",   64'(rej_cnt),   64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst in_ready", 64'(in_ready), 64'd1);

        // First-word latency: two edges from accept to out_valid.
        drive(mkv(2'd0, 5'd5, 5'd2, 5'd0, 3'd3, -64'sd8, 2'd0, 32'hFF813283));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("lat out_valid k", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("lat out_valid k+1", 64'(out_valid), 64'd1);
        check("lat out_instr", 64'(out_instr), 64'hFF813283);
        check("lat acc_cnt", 64'(acc_cnt), 64'd1);
        exp_acc = 1;
        @(posedge clk); #1;
        check("lat empty out_valid", 64'(out_valid), 64'd0);
        check("lat empty holds instr", 64'(out_instr), 64'hFF813283);
        @(negedge clk);

        // Streamed table, one request per cycle with out_ready=1.
        for (int i = 0; i < N + 2; i++) begin
            if (i >= 1) begin
                check($sformatf("vec%0d err_valid", i-1), 64'(err_valid), 64'(tbl[i-1].err != 2'd0));
                check($sformatf("vec%0d err_code", i-1), 64'(err_code), 64'(tbl[i-1].err));
            end
            if (i >= 2) begin
                check($sformatf("vec%0d out_valid", i-2), 64'(out_valid), 64'(tbl[i-2].err == 2'd0));
                if (tbl[i-2].err == 2'd0)
                    check($sformatf("vec%0d out_instr", i-2), 64'(out_instr), 64'(tbl[i-2].instr));
            end
            if (i < N) begin
                drive(tbl[i]);
                check($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'd1);
                if (tbl[i].err == 2'd0) exp_acc++;
                else exp_rej++;
            end else begin
                in_valid = 1'b0;
            end
            next_cycle();
        end
        check("table acc_cnt", 64'(acc_cnt), 64'(exp_acc));
        check("table rej_cnt", 64'(rej_cnt), 64'(exp_rej));

        // Backpressure: fill FIFO plus S1, then drain in order.
        out_ready = 1'b0;
        for (int j = 0; j < 6; j++) begin
            drive(ld_vec(j));
            check($sformatf("bp in_ready req%0d", j), 64'(in_ready), 64'(j < 5));
            if (j >= 2) check($sformatf("bp head stable req%0d", j), 64'(out_instr), 64'(ld_word(0)));
            if (j < 5) next_cycle();
        end
        repeat (2) next_cycle();
        check("bp stalled in_ready", 64'(in_ready), 64'd0);
        check("bp stalled out_valid", 64'(out_valid), 64'd1);
        check("bp stalled out_instr", 64'(out_instr), 64'(ld_word(0)));
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 64'(in_ready), 64'd1);
        next_cycle();
        in_valid = 1'b0;
        for (int j = 1; j < 6; j++) begin
            check($sformatf("bp drain%0d out_valid", j), 64'(out_valid), 64'd1);
            check($sformatf("bp drain%0d out_instr", j), 64'(out_instr), 64'(ld_word(j)));
            next_cycle();
        end
        check("bp drained out_valid", 64'(out_valid), 64'd0);
        check("bp drained out_instr", 64'(out_instr), 64'(ld_word(5)));
        exp_acc += 6;
        check("bp acc_cnt", 64'(acc_cnt), 64'(exp_acc));

        // Asynchronous reset in the middle of a burst.
        out_ready = 1'b0;
        for (int j = 7; j < 10; j++) begin
            drive(ld_vec(j));
            next_cycle();
        end
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("mid rst out_valid", 64'(out_valid), 64'd0);
        check("mid rst out_instr", 64'(out_instr), 64'd0);
        check("mid rst acc_cnt",   64'(acc_cnt),   64'd0);
        check("mid rst rej_cnt",   64'(rej_cnt),   64'd0);
        check("mid rst err_valid", 64'(err_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        drive(tbl[0]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("post rst out_valid", 64'(out_valid), 64'd1);
        check("post rst out_instr", 64'(out_instr), 64'h7E713FA3);
        check("post rst acc_cnt",   64'(acc_cnt),   64'd1);
`ifdef INSTR_ENC_ROUNDTRIP_CHECK_EN
        check("rt_mismatch", 64'(rt_mismatch), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
